// File: rtl/band_scan_scheduler_if.sv
// Sample-input and shared-LED-driver handshake bundle for band_scan_scheduler.
// master is the scheduler side; slave is the sample source / driver side.
interface band_scan_scheduler_if;
    logic       smp_valid;
    logic       smp_ready;
    logic [5:0] smp_freq;
    logic [3:0] smp_amp;
    logic       drv_valid;
    logic       drv_ready;
    logic [1:0] drv_band;
    logic [3:0] drv_level;

    modport master (
        input  smp_valid, smp_freq, smp_amp, drv_ready,
        output smp_ready, drv_valid, drv_band, drv_level
    );

    modport slave (
        output smp_valid, smp_freq, smp_amp, drv_ready,
        input  smp_ready, drv_valid, drv_band, drv_level
    );
endinterface

// File: rtl/band_scan_scheduler.sv
// Per-band peak-hold with periodic decay, and a round-robin scan of the three band peaks
// onto a single shared LED driver with a programmable dwell per band.
module band_scan_scheduler #(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned DECAY_CYCLES = 4096,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    band_scan_scheduler_if.master        bus,
    output logic [3:0]                   peak_low,
    output logic [3:0]                   peak_mid,
    output logic [3:0]                   peak_high,
    output logic [7:0]                   oor_count
);
    localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DecayLast = CNT_W'(DECAY_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StPresent, StDwell} state_e;

    logic             smp_ready_q;
    logic [3:0]       peak_q [3];
    logic [7:0]       oor_q;
    logic [CNT_W-1:0] decay_cnt_q;
    logic [CNT_W-1:0] dwell_cnt_q;
    state_e           state_q;
    logic [1:0]       band_q;
    logic [1:0]       drv_band_q;
    logic [3:0]       drv_level_q;
    logic             drv_valid_q;

    logic             accept;
    logic             tick;
    logic             smp_oor;
    logic [1:0]       smp_band;
    logic [3:0]       load_level;

    always_comb begin
        smp_oor  = 1'b0;
        smp_band = 2'd0;
        if (bus.smp_freq == 6'd0) begin
            smp_oor = 1'b1;
        end else if (bus.smp_freq <= 6'd10) begin
            smp_band = 2'd0;
        end else if (bus.smp_freq <= 6'd28) begin
            smp_band = 2'd1;
        end else begin
            smp_band = 2'd2;
        end
    end

    always_comb begin
        load_level = peak_q[0];
        case (band_q)
            2'd1:    load_level = peak_q[1];
            2'd2:    load_level = peak_q[2];
            default: load_level = peak_q[0];
        endcase
    end

    assign accept = bus.smp_valid && smp_ready_q;
    assign tick   = enable && (decay_cnt_q == DecayLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            smp_ready_q <= 1'b0;
            decay_cnt_q <= '0;
        end else begin
            smp_ready_q <= enable;
            if (enable) begin
                decay_cnt_q <= (decay_cnt_q == DecayLast) ? '0 : decay_cnt_q + 1'b1;
            end
        end
    end

    // A sample landing on a decay tick wins over the decrement for its own band.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                peak_q[b] <= 4'd0;
            end
            oor_q <= 8'd0;
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (accept && !smp_oor && (smp_band == 2'(b))) begin
                    if (bus.smp_amp > peak_q[b]) begin
                        peak_q[b] <= bus.smp_amp;
                    end
                end else if (tick && (peak_q[b] != 4'd0)) begin
                    peak_q[b] <= peak_q[b] - 4'd1;
                end
            end
            if (accept && smp_oor && (oor_q != 8'hFF)) begin
                oor_q <= oor_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            band_q      <= 2'd0;
            drv_band_q  <= 2'd0;
            drv_level_q <= 4'd0;
            drv_valid_q <= 1'b0;
            dwell_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    drv_valid_q <= 1'b0;
                    band_q      <= 2'd0;
                    if (enable) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (!enable) begin
                        state_q <= StIdle;
                        band_q  <= 2'd0;
                    end else begin
                        drv_band_q  <= band_q;
                        drv_level_q <= load_level;
                        drv_valid_q <= 1'b1;
                        state_q     <= StPresent;
                    end
                end
                StPresent: begin
                    // Never withdraw a presented word; disable only takes effect after handshake.
                    if (bus.drv_ready) begin
                        drv_valid_q <= 1'b0;
                        dwell_cnt_q <= '0;
                        if (enable) begin
                            state_q <= StDwell;
                        end else begin
                            state_q <= StIdle;
                            band_q  <= 2'd0;
                        end
                    end
                end
                StDwell: begin
                    if (!enable) begin
                        state_q <= StIdle;
                        band_q  <= 2'd0;
                    end else if (dwell_cnt_q == DwellLast) begin
                        band_q  <= (band_q == 2'd2) ? 2'd0 : band_q + 2'd1;
                        state_q <= StLoad;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.smp_ready = smp_ready_q;
    assign bus.drv_valid = drv_valid_q;
    assign bus.drv_band  = drv_band_q;
    assign bus.drv_level = drv_level_q;
    assign peak_low      = peak_q[0];
    assign peak_mid      = peak_q[1];
    assign peak_high     = peak_q[2];
    assign oor_count     = oor_q;

endmodule

// File: tb/tb_band_scan_scheduler.sv
// Bench for band_scan_scheduler: directed phases plus random traffic, checked every cycle
// against a rule-level model of peaks, decay, overflow count and the scan's timing/band order.
module tb_band_scan_scheduler;
    localparam int DWELL = 4;
    localparam int DECAY = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] peak_low, peak_mid, peak_high;
    logic [7:0] oor_count;

    band_scan_scheduler_if bus ();

    band_scan_scheduler #(
        .DWELL_CYCLES(DWELL),
        .DECAY_CYCLES(DECAY),
        .CNT_W       (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bus      (bus),
        .peak_low (peak_low),
        .peak_mid (peak_mid),
        .peak_high(peak_high),
        .oor_count(oor_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state
    int m_peak [3];
    int m_oor;
    int m_dcnt;
    bit m_ready;
    bit m_presenting;
    bit pending;
    bit expect_low;
    bit wrap_next;
    int exp_rise;
    int next_band;
    int cur_band;
    int cur_level;
    int wraps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic int class_of(input logic [5:0] f);
        if (f == 0) return -1;
        if (f <= 10) return 0;
        if (f <= 28) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_peak       = '{0, 0, 0};
        m_oor        = 0;
        m_dcnt       = 0;
        m_ready      = 1'b0;
        m_presenting = 1'b0;
        pending      = 1'b0;
        expect_low   = 1'b0;
        next_band    = 0;
        cur_band     = 0;
        cur_level    = 0;
    endtask

    task automatic step();
        int  snap [3];
        bit  acc, tk, hs, was_reset;
        int  cls;
        snap      = m_peak;
        was_reset = reset;
        if (reset) begin
            model_reset();
        end else begin
            acc = bus.smp_valid && m_ready;
            tk  = enable && (m_dcnt == DECAY - 1);
            cls = class_of(bus.smp_freq);
            for (int b = 0; b < 3; b++) begin
                if (acc && cls == b) begin
                    if (int'(bus.smp_amp) > m_peak[b]) m_peak[b] = int'(bus.smp_amp);
                end else if (tk && m_peak[b] > 0) begin
                    m_peak[b] = m_peak[b] - 1;
                end
            end
            if (acc && cls < 0 && m_oor < 255) m_oor = m_oor + 1;
            if (enable) m_dcnt = (m_dcnt == DECAY - 1) ? 0 : m_dcnt + 1;
            m_ready = enable;
            hs = m_presenting && bus.drv_ready;
            if (hs) begin
                m_presenting = 1'b0;
                expect_low   = 1'b1;
                if (enable) begin
                    pending   = 1'b1;
                    exp_rise  = cyc + DWELL + 2;
                    next_band = (cur_band + 1) % 3;
                    wrap_next = (cur_band == 2);
                end else begin
                    pending   = 1'b0;
                    next_band = 0;
                end
            end else if (!enable) begin
                pending   = 1'b0;
                next_band = 0;
            end
        end

        @(posedge clk);
        #1;
        cyc++;

        chk("smp_ready", bus.smp_ready, m_ready);
        chk("peak_low", peak_low, m_peak[0]);
        chk("peak_mid", peak_mid, m_peak[1]);
        chk("peak_high", peak_high, m_peak[2]);
        chk("oor_count", oor_count, m_oor);
        if (was_reset) begin
            chk("rst_drv_valid", bus.drv_valid, 0);
            chk("rst_drv_band", bus.drv_band, 0);
            chk("rst_drv_level", bus.drv_level, 0);
        end else if (expect_low) begin
            chk("valid_drop_after_hs", bus.drv_valid, 0);
            expect_low = 1'b0;
        end else if (m_presenting) begin
            chk("present_valid_held", bus.drv_valid, 1);
            chk("present_band_held", bus.drv_band, cur_band);
            chk("present_level_held", bus.drv_level, cur_level);
        end else if (pending) begin
            chk("rise_timing", bus.drv_valid, (cyc == exp_rise) ? 1 : 0);
            if (cyc >= exp_rise) begin
                pending = 1'b0;
                if (wrap_next && next_band == 0) wraps++;
                rise(snap);
            end
        end else if (bus.drv_valid === 1'b1) begin
            rise(snap);
        end
    endtask

    task automatic rise(input int snap [3]);
        chk("rise_band", bus.drv_band, next_band);
        chk("rise_level", bus.drv_level, snap[next_band]);
        m_presenting = 1'b1;
        cur_band     = next_band;
        cur_level    = snap[next_band];
    endtask

    task automatic wait_presenting(input string tag, input int budget);
        int n = 0;
        while (!m_presenting && n < budget) begin
            step();
            n++;
        end
        chk(tag, m_presenting, 1);
    endtask

    initial begin
        logic [5:0] bfreq [6];
        bfreq = '{6'd10, 6'd11, 6'd28, 6'd29, 6'd63, 6'd0};
        wraps = 0;
        wrap_next = 1'b0;
        exp_rise = 0;
        model_reset();
        reset = 1'b1; enable = 1'b0;
        bus.smp_valid = 1'b0; bus.smp_freq = 6'd0; bus.smp_amp = 4'd0; bus.drv_ready = 1'b0;
        step();
        step();

        // Phase 1: first sample right as smp_ready rises; first handshake is band 0.
        reset = 1'b0; enable = 1'b1; bus.drv_ready = 1'b1;
        bus.smp_valid = 1'b1; bus.smp_freq = 6'd5; bus.smp_amp = 4'd9;
        step();
        step();
        bus.smp_valid = 1'b0;
        chk("t1_peak_low", peak_low, 9);
        repeat (20) step();

        // Phase 2: classification boundaries.
        reset = 1'b1; step(); reset = 1'b0;
        bus.drv_ready = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            bus.smp_valid = 1'b1; bus.smp_freq = bfreq[i]; bus.smp_amp = 4'(i + 1);
            step();
        end
        bus.smp_valid = 1'b0;
        chk("t2_peak_low", peak_low, 1);
        chk("t2_peak_mid", peak_mid, 3);
        chk("t2_peak_high", peak_high, 5);
        chk("t2_oor", oor_count, 1);

        // Phase 3: stall in PRESENT, then free-run through band wrap.
        repeat (20) step();
        chk("t3_stalled_valid", bus.drv_valid, 1);
        bus.drv_ready = 1'b1;
        repeat (45) step();
        chk("t3_wrap_seen", (wraps > 0) ? 1 : 0, 1);

        // Phase 4: decay 3 -> 0, then a sample colliding with a tick.
        reset = 1'b1; step(); reset = 1'b0;
        enable = 1'b1;
        step();
        bus.smp_valid = 1'b1; bus.smp_freq = 6'd20; bus.smp_amp = 4'd3;
        step();
        bus.smp_valid = 1'b0;
        repeat (40) step();
        chk("t4_decayed_mid", peak_mid, 0);
        for (int n = 0; n < 16 && m_dcnt != 0; n++) step();
        bus.smp_valid = 1'b1; bus.smp_amp = 4'd3;
        step();
        bus.smp_valid = 1'b0;
        for (int n = 0; n < 16 && m_dcnt != DECAY - 1; n++) step();
        chk("t4_at_tick", m_dcnt, DECAY - 1);
        bus.smp_valid = 1'b1; bus.smp_amp = 4'd2;
        step();
        bus.smp_valid = 1'b0;
        chk("t4_tick_collision_mid", peak_mid, 3);

        // Phase 5: out-of-range counter saturation.
        bus.smp_valid = 1'b1; bus.smp_freq = 6'd0; bus.smp_amp = 4'd15;
        repeat (300) step();
        bus.smp_valid = 1'b0;
        chk("t5_oor_sat", oor_count, 255);

        // Phase 6: disable while presenting, then reset in DWELL.
        bus.drv_ready = 1'b0;
        wait_presenting("t6_wait_present", 30);
        enable = 1'b0;
        repeat (5) step();
        chk("t6_valid_held_disabled", bus.drv_valid, 1);
        bus.drv_ready = 1'b1;
        step();
        step();
        chk("t6_idle_valid", bus.drv_valid, 0);
        chk("t6_idle_ready", bus.smp_ready, 0);
        repeat (3) step();
        enable = 1'b1;
        wait_presenting("t6_wait_restart", 30);
        chk("t6_restart_band", bus.drv_band, 0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_reset_valid", bus.drv_valid, 0);
        chk("t6_reset_peak_low", peak_low, 0);

        // Phase 7: random traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.smp_valid = 1'($urandom % 2);
            bus.smp_freq  = 6'($urandom % 64);
            bus.smp_amp   = 4'($urandom % 16);
            bus.drv_ready = ($urandom % 4) != 0;
            if ($urandom % 64 == 0) enable = ~enable;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/band_scan_scheduler.md
Name: band_scan_scheduler

Overview:
Sits between adc_converter output and the single shared LED driver. Accepts {freq, amp} samples through a valid/ready handshake and keeps a per-band peak-hold level with periodic decay for the low, mid and high bands. Round-robins the shared driver across the three bands, presenting each band's peak through a valid/ready handshake and then holding it for a programmable dwell time.

Parameters:
DWELL_CYCLES, 1000, cycles a band stays on the driver after its handshake completes (>=1)
DECAY_CYCLES, 4096, period in cycles between peak decay ticks (>=2)
CNT_W, 16, width of the dwell and decay counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  1 = accept samples and scan; 0 = stop
smp_valid  in  1  sample valid
smp_ready  out  1  sample ready
smp_freq  in  6  sample frequency code
smp_amp  in  4  sample amplitude
drv_valid  out  1  driver word valid
drv_ready  in  1  driver accepts word
drv_band  out  2  00 low, 01 mid, 10 high
drv_level  out  4  peak level being presented
peak_low  out  4  live peak-hold, low band
peak_mid  out  4  live peak-hold, mid band
peak_high  out  4  live peak-hold, high band
oor_count  out  8  count of accepted freq==0 samples, saturating

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state registers on posedge clk.
- Reset:
  - All outputs are 0, FSM is IDLE, band index is 0.
  - Dwell and decay counters are 0.
  - Reset applied mid-operation aborts any pending handshake; drv_valid is 0 the next cycle.
- Sample input:
  - smp_ready is a register equal to enable, delayed one cycle; it is 0 during reset.
  - A sample is accepted on smp_valid && smp_ready.
- Band classification of an accepted sample:
  - freq 1..10 -> low; 11..28 -> mid; 29..63 -> high.
  - freq 0 -> oor_count += 1, saturating at 255; no peak changes.
- Peak update: on acceptance, peak[b] <= max(peak[b], smp_amp). The new value is visible on peak_* the next cycle.
- Decay counter:
  - Runs only while enable=1. Counts 0..DECAY_CYCLES-1, then wraps to 0.
  - A tick occurs in the cycle the count equals DECAY_CYCLES-1.
  - On a tick, every nonzero peak decrements by 1; a peak at 0 stays 0.
- Simultaneous tick and sample to the same band: the band gets max(peak, amp) with no decrement. The other bands still decay.
- Scan FSM states:
  - IDLE: outputs drv_valid=0. If enable=1, go to LOAD with band=0.
  - LOAD (1 cycle): drv_band <= band; drv_level <= peak[band], snapshotted from the current register value (a sample accepted in this same cycle is not included). Then go to PRESENT.
  - PRESENT: drv_valid=1. drv_band and drv_level are held stable until drv_ready. On drv_valid && drv_ready go to DWELL; drv_valid=0 from the next cycle; dwell counter cleared.
  - DWELL: counter increments each cycle. At DWELL_CYCLES-1, band advances (2 wraps to 0) and the FSM goes to LOAD.
- Timing: handshake in cycle N -> DWELL occupies N+1..N+DWELL_CYCLES -> LOAD at N+DWELL_CYCLES+1 -> drv_valid at N+DWELL_CYCLES+2.
- enable=0:
  - In LOAD or DWELL: next state is IDLE and the band index resets to 0.
  - In PRESENT: drv_valid is never withdrawn without a handshake; the FSM completes the handshake, then goes to IDLE.
  - Peaks and oor_count keep their values while disabled; decay is frozen.
- Widths: the max comparison is 4-bit unsigned. Decrement never underflows. oor_count never wraps.

Test Plan:
1. Reset, enable=1, drv_ready=1, sample (freq=5, amp=9) in the first cycle smp_ready=1 -> peak_low=9 next cycle; the first handshake is band 00 with drv_level equal to the snapshot at LOAD (0 if the sample lands on or after the LOAD cycle, 9 if before).
2. Boundaries, amps 1..6 on freqs 10, 11, 28, 29, 63, 0 -> peak_low=1, peak_mid=3, peak_high=5, oor_count=1.
3. DWELL_CYCLES=4, drv_ready held low 20 cycles in PRESENT -> drv_valid stays 1 with band/level stable; after the handshake at cycle N, LOAD at N+5, drv_valid=1 at N+6 with band advanced; band 10 advances to 00.
4. DECAY_CYCLES=8, peak_mid=3, no samples -> 2, 1, 0 on successive ticks 8 cycles apart, then stays 0. Repeat with a mid sample amp=2 in a tick cycle while peak_mid=3 -> peak_mid stays 3.
5. 300 consecutive accepted freq=0 samples -> oor_count=255, peaks unchanged.
6. enable dropped in PRESENT with drv_ready=0 -> drv_valid stays 1 until drv_ready=1, then IDLE with drv_valid=0 and smp_ready=0. Reset asserted in DWELL -> next cycle all outputs 0, FSM IDLE.
